// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants, request bundle type and index helper
// for the dmem round-robin arbiter (dmem_rr_arbiter, rr_pick).
package dmem_arb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Modulo increment with an explicit wrap, so non-power-of-2
    // requester counts cycle correctly.
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, scans from ptr upward.
// Ports: req (requests), ptr (start index) -> gnt (one-hot), idx, any.
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int               scan;
    logic [PTR_W-1:0] scan_idx;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        scan     = int'(ptr);
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = PTR_W'(scan);
            if (!any && req[scan_idx]) begin
                any           = 1'b1;
                idx           = scan_idx;
                gnt[scan_idx] = 1'b1;
            end
            scan = next_idx(scan, N);
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: round-robin arbiter sharing the single-port dmem
// among NUM_REQ requesters; returns 1-cycle read data to the winner.
// Ports: clk, reset (async, high); req_valid/we/lock/addr/wdata in,
// req_ready out; rsp_valid/rsp_rdata out; mem_en/we/addr/wdata out,
// mem_rdata in. Build option DMEM_ARB_LOCK_EN enables req_lock
// (grant held by the owner for atomic read-modify-write).
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W  = dmem_arb_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] req_eff;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;

    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

`ifdef DMEM_ARB_LOCK_EN
    logic             lock_active;
    logic [PTR_W-1:0] lock_owner;

    // While locked only the owner may compete, even if it is idle.
    always_comb begin
        req_eff = req_valid & {NUM_REQ{~reset}};
        if (lock_active) begin
            req_eff = req_eff & (NUM_REQ'(1) << lock_owner);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (gnt_any) begin
            if (req_lock[gnt_idx]) begin
                lock_active <= 1'b1;
                lock_owner  <= gnt_idx;
            end else begin
                lock_active <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign req_eff     = req_valid & {NUM_REQ{~reset}};
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (req_eff),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready = gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_any) begin
            mem_en    = 1'b1;
            mem_we    = req_we[gnt_idx];
            mem_addr  = addr_a[gnt_idx];
            mem_wdata = wdata_a[gnt_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= gnt & ~req_we;
            if (gnt_any) begin
                rr_ptr <= PTR_W'(next_idx(int'(gnt_idx), NUM_REQ));
            end
        end
    end

    // The macro's read data arrives in the response cycle itself, so it
    // is passed through, gated to zero whenever no response is due.
    assign rsp_rdata = (|rsp_valid) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// tb_dmem_rr_arbiter: directed bench with a behavioural reference model
// and a 16x16 synchronous dmem stand-in.
module tb_dmem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_rr_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [DW-1:0] dmem [16];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= dmem[mem_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: state advanced once per cycle at the negedge.
    int            m_ptr;
    int            m_pend;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] m_mem [16];
    bit            m_lock;
    int            m_owner;
    int            w;
    int            i;
    logic [AW-1:0] a;

    always @(negedge clk) begin
        if (reset) begin
            m_ptr   = 0;
            m_pend  = -1;
            m_lock  = 0;
            m_owner = 0;
            check("rst ready", 32'(req_ready), 32'd0);
            check("rst mem_en", 32'(mem_en), 32'd0);
            check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
            check("rsp_valid", 32'(rsp_valid),
                  (m_pend >= 0) ? (32'd1 << m_pend) : 32'd0);
            check("rsp_rdata", 32'(rsp_rdata),
                  (m_pend >= 0) ? 32'(m_pdata) : 32'd0);
            w = -1;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (w < 0 && req_valid[i] && (!m_lock || i == m_owner))
                    w = i;
            end
            check("ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
            check("mem_en", 32'(mem_en), (w >= 0) ? 32'd1 : 32'd0);
            check("mem_we", 32'(mem_we),
                  (w >= 0) ? 32'(req_we[w]) : 32'd0);
            check("mem_addr", 32'(mem_addr),
                  (w >= 0) ? 32'(req_addr[w*AW +: AW]) : 32'd0);
            check("mem_wdata", 32'(mem_wdata),
                  (w >= 0) ? 32'(req_wdata[w*DW +: DW]) : 32'd0);
            m_pend = -1;
            if (w >= 0) begin
                a     = req_addr[w*AW +: AW];
                m_ptr = (w + 1) % N;
                if (req_we[w]) begin
                    m_mem[a] = req_wdata[w*DW +: DW];
                end else begin
                    m_pend  = w;
                    m_pdata = m_mem[a];
                end
`ifdef DMEM_ARB_LOCK_EN
                if (req_lock[w]) begin
                    m_lock  = 1;
                    m_owner = w;
                end else begin
                    m_lock = 0;
                end
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [AW-1:0] ad,
                           input logic [DW-1:0] d, input logic lk);
        req_valid[r]          = 1'b1;
        req_we[r]             = we;
        req_lock[r]           = lk;
        req_addr[r*AW +: AW]  = ad;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic clr();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
    endtask

    logic [N-1:0]  fair_g [5];
    logic [DW-1:0] fair_d [4];
    logic [N-1:0]  sp_g   [4];
    int            sp_p   [4];

    initial begin
        fair_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        fair_d = '{16'd10, 16'd20, 16'd30, 16'd40};
        sp_g   = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        sp_p   = '{0, 2, 0, 2};
        reset     = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        clr();
        repeat (2) step();

        // reset with everyone requesting
        for (int r = 0; r < N; r++) set_req(r, 1'b1, 4'd0, 16'd0, 1'b0);
        #1;
        check("hold ready", 32'(req_ready), 32'd0);
        check("hold mem_en", 32'(mem_en), 32'd0);
        check("hold rsp", 32'(rsp_valid), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("first grant", 32'(req_ready), 32'b0001);
        step();

        // write then read same address
        clr();
        set_req(0, 1'b1, 4'd3, 16'h1234, 1'b0);
        #1;
        check("wr grant", 32'(req_ready), 32'b0001);
        step();
        clr();
        set_req(1, 1'b0, 4'd3, 16'h0, 1'b0);
        #1;
        check("rd grant", 32'(req_ready), 32'b0010);
        step();
        clr();
        #1;
        check("rd rsp_valid", 32'(rsp_valid), 32'b0010);
        check("rd rsp_rdata", 32'(rsp_rdata), 32'h1234);
        step();

        // preload 0..3 and 5
        for (int v = 0; v < 4; v++) begin
            clr();
            set_req(0, 1'b1, AW'(v), DW'((v + 1) * 10), 1'b0);
            step();
        end
        clr();
        set_req(0, 1'b1, 4'd5, 16'h0555, 1'b0);
        step();
        clr();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // fairness, all four reading
        for (int r = 0; r < N; r++) set_req(r, 1'b0, AW'(r), 16'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("fair grant", 32'(req_ready), 32'(fair_g[k]));
            if (k > 0) check("fair rdata", 32'(rsp_rdata), 32'(fair_d[k-1]));
            step();
        end

        // sparse wrap with rr_ptr at 2
        clr();
        set_req(1, 1'b0, 4'd1, 16'h0, 1'b0);
        step();
        set_req(3, 1'b0, 4'd3, 16'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("sparse grant", 32'(req_ready), 32'(sp_g[k]));
            step();
            check("sparse ptr", 32'(dut.rr_ptr), 32'(sp_p[k]));
        end

        // reset during an outstanding read
        clr();
        set_req(0, 1'b0, 4'd2, 16'h0, 1'b0);
        #1;
        check("mid grant", 32'(req_ready), 32'b0001);
        #6;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid rsp drop", 32'(rsp_valid), 32'd0);
        check("mid ptr", 32'(dut.rr_ptr), 32'd0);
        clr();
        set_req(0, 1'b0, 4'd2, 16'h0, 1'b0);
        set_req(2, 1'b0, 4'd1, 16'h0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check("restart grant", 32'(req_ready), 32'b0001);
        step();
        clr();
        step();

`ifdef DMEM_ARB_LOCK_EN
        // locked read-modify-write by requester 2
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(1, 1'b0, 4'd0, 16'h0, 1'b0);
        step();
        set_req(0, 1'b0, 4'd1, 16'h0, 1'b0);
        set_req(2, 1'b0, 4'd5, 16'h0, 1'b1);
        #1;
        check("lock grant", 32'(req_ready), 32'b0100);
        step();
        req_valid[2] = 1'b0;
        req_lock[2]  = 1'b0;
        #1;
        check("lock rdata", 32'(rsp_rdata), 32'h0555);
        check("lock stall", 32'(req_ready), 32'd0);
        step();
        #1;
        check("lock stall2", 32'(req_ready), 32'd0);
        set_req(2, 1'b1, 4'd5, 16'h0556, 1'b0);
        #1;
        check("unlock grant", 32'(req_ready), 32'b0100);
        step();
        req_valid[2] = 1'b0;
        #1;
        check("after unlock", 32'(req_ready), 32'b0001);
        step();
        clr();
        step();
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Shares the single-port 16x16 data memory (dmem) between NUM_REQ requesters: CPU load/store unit, debug/loader port, and future DMA.
- Grants at most one access per cycle using round-robin priority, drives the memory port, and routes 1-cycle-latency read data back to the winning requester.
- Sits between the CPU core and the dmem macro; the core then issues LOAD/STORE through requester 0.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 4, memory address width (depth 2**ADDR_W)
DATA_W, 16, data word width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester access request
req_we  input  NUM_REQ  1=write, 0=read
req_lock  input  NUM_REQ  hold grant after this transfer (used only with ARB_LOCK_EN)
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  packed write data
req_ready  output  NUM_REQ  one-hot grant; transfer occurs when valid&ready
rsp_valid  output  NUM_REQ  read data valid for requester i
rsp_rdata  output  DATA_W  read data, shared bus
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid 1 cycle after mem_en&!mem_we

Behaviour:
- Reset (async, active-high): rr_ptr=0, rsp_valid=0, rsp_rdata=0, lock_active=0, lock_owner=0.
- req_ready, mem_en, mem_we, mem_addr and mem_wdata are combinational from req_* and state. mem_en=0 forces mem_we=0, mem_addr=0 and mem_wdata=0.
- Arbitration:
  - Pick the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is one-hot or zero, and is never asserted without the matching req_valid.
  - Each grant drives mem_* from the winner's fields.
- rr_ptr update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ on the next edge. With no grant, rr_ptr holds.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Requester rule: once req_valid is asserted, it and all fields stay stable until req_ready. The arbiter does not check this.
- Read response:
  - A granted read in cycle N gives rsp_valid[i]=1 in cycle N+1 only, with rsp_rdata=mem_rdata registered-through (rsp_rdata follows mem_rdata in N+1).
  - rsp_valid is a registered one-hot of the granted read requester.
  - Writes produce no response.
- Back-to-back: a new grant may issue in N+1 while the response from N is returned. Full throughput is 1 access per cycle.
- Reads and writes to the same address in consecutive cycles follow memory order: the write in N is visible to a read granted in N+1.
- Reset mid-operation: any pending response is dropped (rsp_valid=0) and the arbitration state restarts from requester 0.
- Widths: requester index and rr_ptr are $clog2(NUM_REQ) bits. Wrap from NUM_REQ-1 to 0 is explicit, and is correct for non-power-of-2 NUM_REQ.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - A granted transfer with req_lock[i]=1 sets lock_active=1, lock_owner=i.
  - While lock_active, only lock_owner can be granted; other requesters stall with req_ready=0 even if the owner is idle.
  - A granted owner transfer with req_lock=0 clears the lock after that transfer.
  - This supports atomic read-modify-write.
  - rr_ptr still advances on owner grants.
- Undefined: req_lock is ignored, no lock state is built, and arbitration is pure round-robin.

Decomposition:
- Package dmem_arb_pkg:
  - Localparams ADDR_W=4 and DATA_W=16.
  - Typedef mem_req_t (valid, we, lock, addr, wdata).
  - Function next_idx(idx, n) for modulo increment.
- Sub-module rr_pick: purely combinational round-robin priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, index, any.
- Top holds rr_ptr, response and lock registers, plus the mem mux.

Test Plan:
- Reset: reset=1 with all req_valid=1 -> req_ready=0, mem_en=0, rsp_valid=0. Release reset -> first grant goes to requester 0.
- Write then read: req0 writes addr 3 = 16'h1234 in cycle N; req1 reads addr 3 in N+1 -> rsp_valid=4'b0010 in N+2 with rsp_rdata=16'h1234.
- Fairness, NUM_REQ=4: all four hold reads at addr 0..3 (mem preloaded with 10,20,30,40) -> grant order 0,1,2,3,0 and rsp_rdata sequence 10,20,30,40.
- Sparse wrap: only req3 and req1 active, rr_ptr=2 -> grants 3,1,3,1 and rr_ptr values 0,2,0,2.
- Reset mid-read: read granted in N, reset asserted in N+1 before the edge -> rsp_valid stays 0. After release, arbitration restarts from requester 0.
- DMEM_ARB_LOCK_EN: req2 reads addr 5 with lock=1 while req0 and req1 are valid -> req0/1 are stalled until req2 writes addr 5 with lock=0; then req0 is granted next (rr_ptr=3 wraps to 0).
